vga_mem_scheduler: RTL and testbench

//  Owns the single-port video tile memory (WIDTH_MEM x HEIGHT_MEM tiles, one colour each).

---
 rtl/vga_mem_scheduler_pkg.sv | 31 +++
 rtl/vga_mem_scheduler_if.sv | 14 +
 rtl/vga_mem_scheduler_wr_buffer.sv | 42 ++++
 rtl/vga_mem_scheduler.sv | 156 +++++++++++++++
 tb/tb_vga_mem_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_mem_scheduler_pkg.sv
// Shared constants and types for the tile-based VGA memory scheduler.
// The timing controller and the pixel-to-tile adapter use the same geometry.
package vga_mem_scheduler_pkg;

  localparam int WIDTH_VGA    = 640;
  localparam int HEIGHT_VGA   = 480;
  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int WIDTH_MEM    = 40;
  localparam int HEIGHT_MEM   = 30;
  localparam int WIDTH_BLOCK  = 16;
  localparam int HEIGHT_BLOCK = 16;
  localparam int COLOR_W      = 3;
  localparam int ADDR_W       = 11;
  localparam int POS_W        = 10;
  localparam int TILE_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RD_ISSUE   = 2'd1,
    ST_RD_CAPTURE = 2'd2,
    ST_WR         = 2'd3
  } sched_state_t;

  // Row-major tile address; the product is formed at the full address width.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col);
    return row * ADDR_W'(WIDTH_MEM) + col;
  endfunction

endpackage

// File: rtl/vga_mem_scheduler_if.sv
// CPU tile-write channel: valid/ready handshake carrying column, row and colour.
interface vga_mem_scheduler_if;
  import vga_mem_scheduler_pkg::*;

  logic               wrValid;
  logic               wrReady;
  logic [TILE_W-1:0]  wrCol;
  logic [TILE_W-1:0]  wrRow;
  logic [COLOR_W-1:0] wrData;

  modport master (output wrValid, output wrCol, output wrRow, output wrData, input wrReady);
  modport slave  (input wrValid, input wrCol, input wrRow, input wrData, output wrReady);

endinterface

// File: rtl/vga_mem_scheduler_wr_buffer.sv
// One-entry holding register for CPU tile writes; out-of-range requests are
// consumed without buffering and latch the sticky wr_drop flag.
module vga_wr_buffer
  import vga_mem_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  vga_mem_scheduler_if.slave  wr,
  input  logic                drain,
  output logic                buf_vld,
  output logic [ADDR_W-1:0]   buf_addr,
  output logic [COLOR_W-1:0]  buf_data,
  output logic                wr_drop
);

  logic xfer;
  logic in_range;

  assign wr.wrReady = !buf_vld;
  assign xfer       = wr.wrValid && !buf_vld;
  assign in_range   = (int'(wr.wrCol) < WIDTH_MEM) && (int'(wr.wrRow) < HEIGHT_MEM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      wr_drop  <= 1'b0;
    end else begin
      if (xfer && in_range) begin
        buf_vld  <= 1'b1;
        buf_addr <= tile_addr(ADDR_W'(wr.wrRow), ADDR_W'(wr.wrCol));
        buf_data <= wr.wrData;
      end else if (drain) begin
        buf_vld  <= 1'b0;
      end
      if (xfer && !in_range)
        wr_drop <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_mem_scheduler.sv
// Arbitrates the single-port tile RAM between display prefetch (priority) and
// buffered CPU writes, and produces the pixel colour for the current beam position.
module vga_mem_scheduler
  import vga_mem_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pixelEn,
  input  logic [POS_W-1:0]    widthVgaPos,
  input  logic [POS_W-1:0]    heightVgaPos,
  vga_mem_scheduler_if.slave  wr,
  output logic [ADDR_W-1:0]   memAddr,
  output logic                memWe,
  output logic [COLOR_W-1:0]  memWData,
  input  logic [COLOR_W-1:0]  memRData,
  output logic [COLOR_W-1:0]  pixelColor,
  output logic                wrDrop,
  output logic                fetchMiss
);

  sched_state_t       state_q;
  sched_state_t       state_nxt;

  int                 xi;
  int                 yi;
  int                 nyi;
  logic               tile_trig;
  logic               line_trig;
  logic               trig;
  logic [ADDR_W-1:0]  trig_addr;

  logic               fetch_pend;
  logic               fetch_miss;
  logic [ADDR_W-1:0]  fetch_addr;

  logic               buf_vld;
  logic [ADDR_W-1:0]  buf_addr;
  logic [COLOR_W-1:0] buf_data;
  logic               drain;

  logic [COLOR_W-1:0] next_tile_p0;
  logic [COLOR_W-1:0] cur_tile_p1;

  vga_wr_buffer u_wr_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .drain    (drain),
    .buf_vld  (buf_vld),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .wr_drop  (wrDrop)
  );

  assign xi  = int'(widthVgaPos);
  assign yi  = int'(heightVgaPos);
  assign nyi = (yi == V_TOTAL - 1) ? 0 : yi + 1;

  // Last pixel of a tile prefetches the next tile on the same line; the last
  // pixel of a line prefetches column 0 of the line that follows.
  assign tile_trig = pixelEn && (xi % WIDTH_BLOCK == WIDTH_BLOCK - 1) &&
                     (xi < WIDTH_VGA - 1) && (yi < HEIGHT_VGA);
  assign line_trig = pixelEn && (xi == H_TOTAL - 1) && (nyi < HEIGHT_VGA);
  assign trig      = tile_trig || line_trig;

  always_comb begin
    trig_addr = '0;
    if (line_trig)
      trig_addr = tile_addr(ADDR_W'(nyi / HEIGHT_BLOCK), '0);
    else if (tile_trig)
      trig_addr = tile_addr(ADDR_W'(yi / HEIGHT_BLOCK), ADDR_W'((xi + 1) / WIDTH_BLOCK));
  end

  // A new trigger always replaces the pending target; colliding with an
  // unserved one is recorded in the sticky miss flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pend <= 1'b0;
      fetch_addr <= '0;
      fetch_miss <= 1'b0;
    end else if (trig) begin
      fetch_pend <= 1'b1;
      fetch_addr <= trig_addr;
      if (fetch_pend)
        fetch_miss <= 1'b1;
    end else if (state_q == ST_RD_ISSUE) begin
      fetch_pend <= 1'b0;
    end
  end

  assign fetchMiss = fetch_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_nxt;
  end

  // The live trigger is considered alongside fetch_pend so an idle port starts
  // the read one clock earlier, leaving room for a write that is already committed.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_pend || trig)
          state_nxt = ST_RD_ISSUE;
        else if (buf_vld)
          state_nxt = ST_WR;
      end
      ST_RD_ISSUE:   state_nxt = ST_RD_CAPTURE;
      ST_RD_CAPTURE: state_nxt = ST_IDLE;
      ST_WR:         state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    memAddr  = '0;
    memWe    = 1'b0;
    memWData = '0;
    drain    = 1'b0;
    case (state_q)
      ST_RD_ISSUE: begin
        memAddr = fetch_addr;
      end
      ST_WR: begin
        memAddr  = buf_addr;
        memWe    = 1'b1;
        memWData = buf_data;
        drain    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // p0: tile colour captured from the RAM one clock after the read address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      next_tile_p0 <= '0;
    else if (state_q == ST_RD_CAPTURE)
      next_tile_p0 <= memRData;
  end

  // p1: tile colour on display, advanced at each tile boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cur_tile_p1 <= '0;
    else if (pixelEn && (xi % WIDTH_BLOCK == 0))
      cur_tile_p1 <= next_tile_p0;
  end

  assign pixelColor = ((xi < WIDTH_VGA) && (yi < HEIGHT_VGA)) ? cur_tile_p1 : '0;

endmodule

// File: tb/tb_vga_mem_scheduler.sv
// Directed bench for vga_mem_scheduler: behavioural sync tile RAM preloaded
// with addr%8, pixel periods of 4 clocks, CPU writes through the interface.
module tb_vga_mem_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixelEn;
  logic [9:0]  hx;
  logic [9:0]  hy;
  logic [10:0] memAddr;
  logic        memWe;
  logic [2:0]  memWData;
  logic [2:0]  memRData;
  logic [2:0]  pixelColor;
  logic        wrDrop;
  logic        fetchMiss;

  int total = 0;
  int bad   = 0;

  int          we_count = 0;
  logic [10:0] last_addr = '0;
  logic [2:0]  last_data = '0;
  bit          wflag [0:1199];
  logic [2:0]  wval  [0:1199];

  vga_mem_scheduler_if wif ();

  vga_mem_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .pixelEn      (pixelEn),
    .widthVgaPos  (hx),
    .heightVgaPos (hy),
    .wr           (wif),
    .memAddr      (memAddr),
    .memWe        (memWe),
    .memWData     (memWData),
    .memRData     (memRData),
    .pixelColor   (pixelColor),
    .wrDrop       (wrDrop),
    .fetchMiss    (fetchMiss)
  );

  always #5 clk = ~clk;

  // Sync RAM: unwritten locations read as addr%8.
  always @(posedge clk) begin
    if (memWe) begin
      we_count  <= we_count + 1;
      last_addr <= memAddr;
      last_data <= memWData;
      if (memAddr < 11'd1200) begin
        wflag[memAddr] <= 1'b1;
        wval[memAddr]  <= memWData;
      end
    end
    if (memAddr < 11'd1200)
      memRData <= wflag[memAddr] ? wval[memAddr] : memAddr[2:0];
    else
      memRData <= 3'd0;
  end

  task automatic pix(input int x, input int y);
    @(negedge clk);
    hx = 10'(x);
    hy = 10'(y);
    pixelEn = 1'b1;
    @(negedge clk);
    pixelEn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_write(input int c, input int r, input int d, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    wif.wrValid = 1'b1;
    wif.wrCol   = 6'(c);
    wif.wrRow   = 6'(r);
    wif.wrData  = 3'(d);
    while (wif.wrReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (wif.wrReady === 1'b1);
    @(negedge clk);
    wif.wrValid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    int w0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if ({memWe, memAddr, memWData} !== 15'd0) begin bad++; $display("FAIL reset_mem: got we=%0d addr=%0d data=%0d want 0", memWe, memAddr, memWData); end
    total++; if (wif.wrReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0d want 1", wif.wrReady); end
    total++; if ({pixelColor, wrDrop, fetchMiss} !== 5'd0) begin bad++; $display("FAIL reset_out: got color=%0d drop=%0d miss=%0d want 0", pixelColor, wrDrop, fetchMiss); end
    pix(15, 100);
    pix(16, 100);
    total++; if (pixelColor !== 3'd1) begin bad++; $display("FAIL pre_color: got %0d want 1", pixelColor); end
    cpu_write(40, 0, 1, ok);
    total++; if (wrDrop !== 1'b1) begin bad++; $display("FAIL pre_drop: got %0d want 1", wrDrop); end
    @(negedge clk); hx = 10'd31; hy = 10'd100; pixelEn = 1'b1;
    @(negedge clk); hx = 10'd47;
    @(negedge clk); pixelEn = 1'b0; hx = 10'd16;
    repeat (3) @(negedge clk);
    total++; if (fetchMiss !== 1'b1) begin bad++; $display("FAIL pre_miss: got %0d want 1", fetchMiss); end
    w0 = we_count;
    cpu_write(3, 0, 7, ok);
    n = 0;
    while (memWe !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (memWe !== 1'b1) begin bad++; $display("FAIL wr_start: got %0d want 1", memWe); end
    rst = 1'b1;
    #1;
    total++; if (memWe !== 1'b0) begin bad++; $display("FAIL rst_we: got %0d want 0", memWe); end
    total++; if (wif.wrReady !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0d want 1", wif.wrReady); end
    total++; if (pixelColor !== 3'd0) begin bad++; $display("FAIL rst_color: got %0d want 0", pixelColor); end
    total++; if ({wrDrop, fetchMiss} !== 2'd0) begin bad++; $display("FAIL rst_sticky: got drop=%0d miss=%0d want 0", wrDrop, fetchMiss); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (we_count !== w0) begin bad++; $display("FAIL rst_aborted_wr: got %0d writes want %0d", we_count, w0); end
  endtask

  task automatic test_sweep();
    int exp_c;
    pix(799, 99);
    for (int x = 0; x <= 37; x++) begin
      pix(x, 100);
      if (x == 0 || x == 16 || x == 37) begin
        exp_c = (x == 0) ? 0 : (x == 16) ? 1 : 2;
        total++;
        if (pixelColor !== 3'(exp_c)) begin bad++; $display("FAIL sweep_x%0d: got %0d want %0d", x, pixelColor, exp_c); end
      end
    end
    total++; if (fetchMiss !== 1'b0) begin bad++; $display("FAIL sweep_miss: got %0d want 0", fetchMiss); end
  endtask

  task automatic test_back_to_back();
    int w0;
    bit tmo;
    w0 = we_count;
    tmo = 1'b0;
    fork
      begin
        pix(799, 15);
        for (int x = 0; x < 208; x++) begin
          pix(x, 16);
          if (x % 16 == 3) begin
            total++;
            if (pixelColor !== 3'((x / 16) % 8)) begin bad++; $display("FAIL b2b_x%0d: got %0d want %0d", x, pixelColor, (x / 16) % 8); end
          end
        end
      end
      begin
        int n;
        @(negedge clk);
        wif.wrValid = 1'b1;
        for (int i = 0; i < 40; i++) begin
          wif.wrCol  = 6'(i);
          wif.wrRow  = 6'd28;
          wif.wrData = 3'((i % 7) + 1);
          n = 0;
          while (wif.wrReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
          end
          if (n >= 50) tmo = 1'b1;
          @(negedge clk);
        end
        wif.wrValid = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL b2b_ready_timeout: got %0d want 0", tmo); end
    total++; if (we_count - w0 !== 40) begin bad++; $display("FAIL b2b_writes: got %0d want 40", we_count - w0); end
    total++; if (wval[1120] !== 3'd1 || wval[1159] !== 3'd5) begin bad++; $display("FAIL b2b_data: got %0d,%0d want 1,5", wval[1120], wval[1159]); end
    total++; if (fetchMiss !== 1'b0) begin bad++; $display("FAIL b2b_miss: got %0d want 0", fetchMiss); end
  endtask

  task automatic test_write_corner();
    bit ok;
    int w0;
    w0 = we_count;
    cpu_write(39, 29, 5, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL corner_accept: got %0d want 1", ok); end
    repeat (4) @(negedge clk);
    total++; if (we_count - w0 !== 1) begin bad++; $display("FAIL corner_pulse: got %0d want 1", we_count - w0); end
    total++; if (last_addr !== 11'd1199 || last_data !== 3'd5) begin bad++; $display("FAIL corner_addr: got addr=%0d data=%0d want 1199,5", last_addr, last_data); end
    total++; if (wif.wrReady !== 1'b1) begin bad++; $display("FAIL corner_ready: got %0d want 1", wif.wrReady); end
    pix(623, 479);
    pix(624, 479);
    pix(639, 479);
    total++; if (pixelColor !== 3'd5) begin bad++; $display("FAIL corner_pixel: got %0d want 5", pixelColor); end
    pix(640, 479);
    total++; if (pixelColor !== 3'd0) begin bad++; $display("FAIL corner_hblank: got %0d want 0", pixelColor); end
    pix(639, 480);
    total++; if (pixelColor !== 3'd0) begin bad++; $display("FAIL corner_vblank: got %0d want 0", pixelColor); end
  endtask

  task automatic test_drop();
    bit ok;
    int w0;
    w0 = we_count;
    total++; if (wrDrop !== 1'b0) begin bad++; $display("FAIL drop_before: got %0d want 0", wrDrop); end
    cpu_write(40, 0, 3, ok);
    total++; if (wrDrop !== 1'b1) begin bad++; $display("FAIL drop_col: got %0d want 1", wrDrop); end
    total++; if (wif.wrReady !== 1'b1) begin bad++; $display("FAIL drop_ready: got %0d want 1", wif.wrReady); end
    cpu_write(0, 30, 3, ok);
    repeat (4) @(negedge clk);
    total++; if (we_count - w0 !== 0) begin bad++; $display("FAIL drop_no_we: got %0d want 0", we_count - w0); end
    total++; if (wif.wrReady !== 1'b1) begin bad++; $display("FAIL drop_ready_after: got %0d want 1", wif.wrReady); end
  endtask

  task automatic test_wrap();
    bit ok;
    cpu_write(0, 0, 6, ok);
    repeat (4) @(negedge clk);
    pix(15, 0);
    pix(799, 523);
    pix(0, 0);
    total++; if (pixelColor !== 3'd1) begin bad++; $display("FAIL wrap_skip_523: got %0d want 1", pixelColor); end
    pix(799, 524);
    pix(0, 0);
    total++; if (pixelColor !== 3'd6) begin bad++; $display("FAIL wrap_frame: got %0d want 6", pixelColor); end
    total++; if (fetchMiss !== 1'b0) begin bad++; $display("FAIL wrap_miss: got %0d want 0", fetchMiss); end
  endtask

  initial begin
    rst = 1'b1;
    pixelEn = 1'b0;
    hx = '0;
    hy = '0;
    wif.wrValid = 1'b0;
    wif.wrCol   = '0;
    wif.wrRow   = '0;
    wif.wrData  = '0;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_write_corner();
    test_drop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
